// File: rtl/flap_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : flap_game_ctrl_if
// Brief    : Signal bundle between the game controller and its datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface flap_game_ctrl_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       is_bottom;
  logic       pipe_hit;
  logic       eat_coin;
  logic [1:0] game_state;
  logic [7:0] space_trigger;
  logic [9:0] score;
  logic [9:0] high_score;
  logic       new_game;

  // Environment side: drives keyboard/bird/pipe status, observes the controller.
  modport master (
    output frame_clk, keycode, is_bottom, pipe_hit, eat_coin,
    input  game_state, space_trigger, score, high_score, new_game
  );

  // Controller side.
  modport slave (
    input  frame_clk, keycode, is_bottom, pipe_hit, eat_coin,
    output game_state, space_trigger, score, high_score, new_game
  );
endinterface
`default_nettype wire

// File: rtl/flap_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flap_game_ctrl
// Brief    : Flappy Bird sequencer - frame-aligned flap requests, IDLE/PLAY/DEAD
//            state machine, score and high-score keeping.
// Revision : 1.0 - initial release
// ============================================================================
module flap_game_ctrl #(
  parameter logic [7:0] SPACE_KEY        = 8'h2C,
  parameter logic [9:0] DEAD_HOLD_FRAMES = 10'd90,
  parameter logic [9:0] SCORE_MAX        = 10'd999
) (
  input  logic            Clk,
  input  logic            Reset,
  flap_game_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_DEAD = 2'b10;

  logic       r_frame_d;
  logic       r_frame_rise;
  logic       r_key_d;
  logic       r_coin_d;
  logic [1:0] r_state;
  logic       r_flap;
  logic       r_new_game;
  logic [9:0] r_score;
  logic [9:0] r_high_score;
  logic [9:0] r_hold;

  logic       w_press;
  logic       w_coin_rise;
  logic       w_die;
  logic       w_hold_done;
  logic [9:0] w_score_next;

  assign w_press     = (bus.keycode == SPACE_KEY) & ~r_key_d;
  assign w_coin_rise = bus.eat_coin & ~r_coin_d;
  assign w_die       = bus.is_bottom | bus.pipe_hit;
  assign w_hold_done = (r_hold == DEAD_HOLD_FRAMES);

  // Score including this cycle's coin, so a coin on the death cycle reaches high_score.
  always_comb begin
    w_score_next = r_score;
    if ((r_state == S_PLAY) && w_coin_rise && (r_score < SCORE_MAX))
      w_score_next = r_score + 10'd1;
  end

  // Same two-flop frame edge timing as the bird block.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_d    <= 1'b0;
      r_frame_rise <= 1'b0;
      r_key_d      <= 1'b0;
      r_coin_d     <= 1'b0;
    end else begin
      r_frame_d    <= bus.frame_clk;
      r_frame_rise <= bus.frame_clk & ~r_frame_d;
      r_key_d      <= (bus.keycode == SPACE_KEY);
      r_coin_d     <= bus.eat_coin;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_flap       <= 1'b0;
      r_new_game   <= 1'b0;
      r_score      <= 10'd0;
      r_high_score <= 10'd0;
      r_hold       <= 10'd0;
    end else begin
      r_new_game <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_flap <= 1'b0;
          if (w_press) begin
            r_state    <= S_PLAY;
            r_score    <= 10'd0;
            r_new_game <= 1'b1;
            r_flap     <= 1'b1;
          end
        end
        S_PLAY: begin
          r_score <= w_score_next;
          if (w_die) begin
            r_state <= S_DEAD;
            r_hold  <= 10'd0;
            r_flap  <= 1'b0;
            if (w_score_next > r_high_score)
              r_high_score <= w_score_next;
          end else if (w_press) begin
            r_flap <= 1'b1;
          end else if (r_frame_rise) begin
            r_flap <= 1'b0;
          end
        end
        S_DEAD: begin
          r_flap <= 1'b0;
          if (w_press && w_hold_done)
            r_state <= S_IDLE;
          else if (r_frame_rise && !w_hold_done)
            r_hold <= r_hold + 10'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_flap  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.game_state    = r_state;
  assign bus.space_trigger = {8{r_flap}};
  assign bus.score         = r_score;
  assign bus.high_score    = r_high_score;
  assign bus.new_game      = r_new_game;

endmodule
`default_nettype wire

// File: tb/tb_flap_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flap_game_ctrl
// Brief    : Self-checking bench for flap_game_ctrl against a game-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flap_game_ctrl;

  localparam int         FP   = 12;
  localparam int         HOLD = 90;
  localparam int         SMAX = 999;
  localparam logic [7:0] KEY  = 8'h2C;

  logic Clk = 1'b0;
  logic Reset;

  flap_game_ctrl_if bus ();

  flap_game_ctrl #(
    .SPACE_KEY       (KEY),
    .DEAD_HOLD_FRAMES(10'd90),
    .SCORE_MAX       (10'd999)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Game-rule model: 0 idle, 1 playing, 2 dead.
  int m_state, m_score, m_high, m_hold;
  bit m_flap, m_new;
  bit m_fd, m_fr, m_kd, m_cd;
  bit auto_frame;
  int fcnt;

  wire [30:0] obs = {bus.game_state, bus.space_trigger, bus.score, bus.high_score, bus.new_game};

  function automatic logic [30:0] expect_bus();
    return {m_state[1:0], (m_flap ? 8'hFF : 8'h00), m_score[9:0], m_high[9:0], m_new};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_hold = 0;
    m_flap = 0; m_new = 0; m_fd = 0; m_fr = 0; m_kd = 0; m_cd = 0;
  endtask

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    bit press, coin, fr;
    if (auto_frame) begin
      fcnt++;
      bus.frame_clk = ((fcnt % FP) < 4);
    end
    @(posedge Clk);
    if (Reset) begin
      model_reset();
    end else begin
      press = (bus.keycode == KEY) && !m_kd;
      coin  = bus.eat_coin && !m_cd;
      fr    = m_fr;
      m_new = 0;
      if (m_state == 0) begin
        m_flap = 0;
        if (press) begin m_state = 1; m_score = 0; m_new = 1; m_flap = 1; end
      end else if (m_state == 1) begin
        if (coin && m_score < SMAX) m_score++;
        if (bus.is_bottom || bus.pipe_hit) begin
          m_state = 2; m_hold = 0; m_flap = 0;
          if (m_score > m_high) m_high = m_score;
        end else if (press) m_flap = 1;
        else if (fr) m_flap = 0;
      end else begin
        m_flap = 0;
        if (press && m_hold == HOLD) m_state = 0;
        else if (fr && m_hold < HOLD) m_hold++;
      end
      m_fr = bus.frame_clk && !m_fd;
      m_fd = bus.frame_clk;
      m_kd = (bus.keycode == KEY);
      m_cd = bus.eat_coin;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.keycode = 8'h00; bus.is_bottom = 0; bus.pipe_hit = 0; bus.eat_coin = 0; bus.frame_clk = 0;
    auto_frame = 1; fcnt = int'($urandom_range(0, FP - 1));
    tick(); tick();
    Reset = 1'b0;
    n_cmp++;
    if (obs !== 31'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    for (int i = 0; i < 8; i++) begin
      bus.keycode = 8'(($urandom_range(0, 1) == 0) ? 8'h00 : 8'h1A);
      tick();
    end
    bus.keycode = 8'h00;
    n_cmp++;
    if (bus.game_state !== 2'b00) begin n_err++; $display("FAIL idle_other_key: got %0d want 0", bus.game_state); end
  endtask

  task automatic test_start();
    bit last_fr;
    int n;
    n = int'($urandom_range(1, 10));
    for (int i = 0; i < n; i++) tick();
    bus.keycode = KEY;
    tick();
    n_cmp++;
    if (bus.game_state !== 2'b01 || bus.new_game !== 1'b1 || bus.space_trigger !== 8'hFF || bus.score !== 10'd0) begin
      n_err++;
      $display("FAIL start_edge: got st=%0d ng=%0d sp=%h sc=%0d want 1 1 ff 0",
               bus.game_state, bus.new_game, bus.space_trigger, bus.score);
    end
    tick();
    n_cmp++;
    if (bus.new_game !== 1'b0 || bus.game_state !== 2'b01) begin
      n_err++; $display("FAIL new_game_width: got ng=%0d st=%0d want 0 1", bus.new_game, bus.game_state);
    end
    tick();
    bus.keycode = 8'h00;
    last_fr = m_fr;
    for (int i = 0; i < 3 * FP; i++) begin
      last_fr = m_fr;
      tick();
      n_cmp++;
      if (bus.space_trigger !== (m_flap ? 8'hFF : 8'h00)) begin
        n_err++; $display("FAIL start_flap_cycle: got %h want %h", bus.space_trigger, m_flap ? 8'hFF : 8'h00);
      end
      if (!m_flap) break;
    end
    n_cmp++;
    if (bus.space_trigger !== 8'h00 || last_fr !== 1'b1) begin
      n_err++; $display("FAIL start_flap_clear: got sp=%h prev_rise=%0d want 00 1", bus.space_trigger, last_fr);
    end
  endtask

  task automatic test_hold_key();
    int rises_ff;
    tick(); tick();
    rises_ff = 0;
    bus.keycode = KEY;
    for (int i = 0; i < 5 * FP; i++) begin
      tick();
      if (m_fr && bus.space_trigger === 8'hFF) rises_ff++;
      n_cmp++;
      if (obs !== expect_bus()) begin n_err++; $display("FAIL hold_cycle: got %h want %h", obs, expect_bus()); end
    end
    n_cmp++;
    if (rises_ff != 1) begin n_err++; $display("FAIL hold_one_flap: got %0d want 1", rises_ff); end
    bus.keycode = 8'h00;
    repeat (int'($urandom_range(2, 5))) tick();
    rises_ff = 0;
    bus.keycode = KEY;
    tick();
    bus.keycode = 8'h00;
    if (m_fr && bus.space_trigger === 8'hFF) rises_ff++;
    for (int i = 0; i < 2 * FP; i++) begin
      tick();
      if (m_fr && bus.space_trigger === 8'hFF) rises_ff++;
    end
    n_cmp++;
    if (rises_ff != 1 || bus.space_trigger !== 8'h00) begin
      n_err++; $display("FAIL repress_one_flap: got %0d sp=%h want 1 00", rises_ff, bus.space_trigger);
    end
  endtask

  task automatic test_press_on_frame();
    bus.keycode = KEY; tick();
    bus.keycode = 8'h00; tick();
    for (int i = 0; i < 2 * FP && !m_fr; i++) tick();
    bus.keycode = KEY;
    tick();
    bus.keycode = 8'h00;
    n_cmp++;
    if (bus.space_trigger !== 8'hFF) begin n_err++; $display("FAIL aligned_press_hold: got %h want ff", bus.space_trigger); end
    for (int i = 0; i < 2 * FP && !m_fr; i++) begin
      tick();
      n_cmp++;
      if (bus.space_trigger !== 8'hFF) begin n_err++; $display("FAIL aligned_next_frame: got %h want ff", bus.space_trigger); end
    end
    tick();
    n_cmp++;
    if (bus.space_trigger !== 8'h00) begin n_err++; $display("FAIL aligned_clear: got %h want 00", bus.space_trigger); end
  endtask

  task automatic test_score();
    for (int k = 0; k < 3; k++) begin
      bus.eat_coin = 1'b1; repeat (4) tick();
      bus.eat_coin = 1'b0; repeat (int'($urandom_range(1, 5))) tick();
    end
    n_cmp++;
    if (bus.score !== 10'd3 || bus.high_score !== 10'd0) begin
      n_err++; $display("FAIL score_three: got sc=%0d hi=%0d want 3 0", bus.score, bus.high_score);
    end
    for (int k = 0; k < 995; k++) begin
      bus.eat_coin = 1'b1; tick();
      bus.eat_coin = 1'b0; tick();
    end
    n_cmp++;
    if (bus.score !== 10'd998) begin n_err++; $display("FAIL score_998: got %0d want 998", bus.score); end
    for (int k = 0; k < 3; k++) begin
      bus.eat_coin = 1'b1; repeat (int'($urandom_range(1, 3))) tick();
      bus.eat_coin = 1'b0; tick();
    end
    n_cmp++;
    if (bus.score !== 10'(SMAX) || bus.game_state !== 2'b01) begin
      n_err++; $display("FAIL score_saturate: got sc=%0d st=%0d want 999 1", bus.score, bus.game_state);
    end
  endtask

  task automatic test_death();
    Reset = 1'b1; tick(); Reset = 1'b0;
    bus.keycode = KEY; tick(); bus.keycode = 8'h00; tick();
    for (int k = 0; k < 7; k++) begin
      bus.eat_coin = 1'b1; repeat (int'($urandom_range(1, 4))) tick();
      bus.eat_coin = 1'b0; tick();
    end
    if ($urandom_range(0, 1) == 0) bus.is_bottom = 1'b1; else bus.pipe_hit = 1'b1;
    tick();
    bus.pipe_hit = 1'b0;
    n_cmp++;
    if (bus.game_state !== 2'b10 || bus.high_score !== 10'd7 || bus.space_trigger !== 8'h00) begin
      n_err++; $display("FAIL death_enter: got st=%0d hi=%0d sp=%h want 2 7 00",
                        bus.game_state, bus.high_score, bus.space_trigger);
    end
    for (int i = 0; i < 20 * FP && m_hold < 10; i++) tick();
    bus.keycode = KEY; tick(); bus.keycode = 8'h00; tick();
    n_cmp++;
    if (m_hold < 10 || bus.game_state !== 2'b10) begin
      n_err++; $display("FAIL dead_press_early: got st=%0d hold=%0d want 2 >=10", bus.game_state, m_hold);
    end
    for (int i = 0; i < 100 * FP && m_hold < HOLD - 1; i++) tick();
    bus.keycode = KEY; tick(); bus.keycode = 8'h00; tick();
    n_cmp++;
    if (bus.game_state !== 2'b10) begin n_err++; $display("FAIL dead_press_89: got st=%0d want 2", bus.game_state); end
    for (int i = 0; i < 10 * FP && m_hold < HOLD; i++) tick();
    bus.keycode = KEY; tick();
    n_cmp++;
    if (m_hold != HOLD || bus.game_state !== 2'b00 || bus.space_trigger !== 8'h00 || bus.high_score !== 10'd7) begin
      n_err++; $display("FAIL dead_exit: got st=%0d sp=%h hi=%0d hold=%0d want 0 00 7 90",
                        bus.game_state, bus.space_trigger, bus.high_score, m_hold);
    end
    bus.keycode = 8'h00; bus.is_bottom = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.keycode = KEY; tick(); bus.keycode = 8'h00; tick();
    // Press, coin and pipe hit all land together: death wins, coin still counts.
    bus.keycode = KEY; bus.pipe_hit = 1'b1; bus.eat_coin = 1'b1;
    tick();
    bus.keycode = 8'h00; bus.pipe_hit = 1'b0; bus.eat_coin = 1'b0;
    n_cmp++;
    if (bus.game_state !== 2'b10 || bus.space_trigger !== 8'h00 || bus.score !== 10'd1 || bus.high_score !== 10'd7) begin
      n_err++; $display("FAIL death_priority: got st=%0d sp=%h sc=%0d hi=%0d want 2 00 1 7",
                        bus.game_state, bus.space_trigger, bus.score, bus.high_score);
    end
    repeat (int'($urandom_range(2, 30))) tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    n_cmp++;
    if (obs !== 31'd0) begin n_err++; $display("FAIL reset_mid_game: got %h want 0", obs); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: bus.keycode = 8'h00;
          1: bus.keycode = KEY;
          default: bus.keycode = 8'($urandom_range(1, 255));
        endcase
      end
      if ($urandom_range(0, 3) == 0) bus.eat_coin = ~bus.eat_coin;
      bus.is_bottom = ($urandom_range(0, 399) == 0);
      bus.pipe_hit  = ($urandom_range(0, 399) == 0);
      Reset         = ($urandom_range(0, 2999) == 0);
      tick();
      n_cmp++;
      if (obs !== expect_bus()) begin n_err++; $display("FAIL random_cycle %0d: got %h want %h", i, obs, expect_bus()); end
    end
    Reset = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_hold_key();
    test_press_on_frame();
    test_score();
    test_death();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
